// File: rtl/sort_circuit.sv
// ---------------------------------------------------------------------------
// sort_circuit
//
// Sorts a block of words held in an external memory in place, ascending and
// unsigned, using a bubble sort. The memory is reached through five
// independent valid/ready channels. Only one bus transaction is ever in
// flight.
//
// Bubble sort loop structure:
//   passes p = 0 .. N-2
//   inner  j = 0 .. N-2-p
//   read A[j] and A[j+1], swap them if A[j] > A[j+1]
//
// Parameters
//   ADDR_WDTH  memory address width; the design sorts up to 2**ADDR_WDTH words
//   DATA_WDTH  width of one element (unsigned)
//   RESP_WDTH  width of r_resp / b_resp (0 = OKAY, anything else = error)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   arr_size             number of elements (addresses 0 .. arr_size-1)
//   start                level request; sampled in IDLE
//   done, err            operation finished / finished with an error
//   ar_*                 read address channel   (master -> memory)
//   r_*                  read data channel      (memory -> master)
//   aw_*, w_*            write address / data   (master -> memory)
//   b_*                  write response channel (memory -> master)
//   swich_case_default   sticky: the state register held an unused encoding
// ---------------------------------------------------------------------------
module sort_circuit #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic [ADDR_WDTH:0]   arr_size,
  input  logic                 start,
  output logic                 done,
  output logic                 err,

  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,

  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,

  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,

  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,

  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp,

  output logic                 swich_case_default
);

  // Largest legal size is a full memory; anything at or below one element
  // is trivially sorted.
  localparam logic [ADDR_WDTH:0] MAX_SIZE = {1'b1, {ADDR_WDTH{1'b0}}};
  localparam logic [ADDR_WDTH:0] SIZE_ONE = {{ADDR_WDTH{1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RD_A_ADDR = 4'd1,
    RD_A_DATA = 4'd2,
    RD_B_ADDR = 4'd3,
    RD_B_DATA = 4'd4,
    COMPARE   = 4'd5,
    WR_A      = 4'd6,
    WR_A_RESP = 4'd7,
    WR_B      = 4'd8,
    WR_B_RESP = 4'd9,
    NEXT      = 4'd10,
    DONE      = 4'd11
  } state_t;

  state_t                 state_q,     state_d;
  logic [ADDR_WDTH:0]     size_q,      size_d;
  logic [ADDR_WDTH-1:0]   p_q,         p_d;
  logic [ADDR_WDTH-1:0]   j_q,         j_d;
  logic [DATA_WDTH-1:0]   a_q,         a_d;
  logic [DATA_WDTH-1:0]   b_q,         b_d;
  logic                   err_q,       err_d;
  logic                   aw_done_q,   aw_done_d;
  logic                   w_done_q,    w_done_d;
  logic                   bad_state_q, bad_state_d;

  logic                   aw_fire;
  logic                   w_fire;

  // Loop bookkeeping. j+p+2 == N marks the last compare of a pass, and
  // p+2 == N marks the final pass; both together mark the final compare of
  // the whole sort, after which the FSM goes straight to DONE so that done
  // rises one cycle after the last handshake.
  logic [ADDR_WDTH:0]     pair_end;
  logic [ADDR_WDTH:0]     pass_end;
  logic                   end_of_pass;
  logic                   last_pass;
  logic                   last_pair;
  logic [ADDR_WDTH-1:0]   j_plus1;

  assign pair_end    = {1'b0, j_q} + {1'b0, p_q} + (ADDR_WDTH+1)'(2);
  assign pass_end    = {1'b0, p_q} + (ADDR_WDTH+1)'(2);
  assign end_of_pass = (pair_end == size_q);
  assign last_pass   = (pass_end == size_q);
  assign last_pair   = end_of_pass && last_pass;
  assign j_plus1     = j_q + ADDR_WDTH'(1);

  assign err                = err_q;
  assign swich_case_default = bad_state_q;

  // State and datapath registers. Reset returns to IDLE with every counter,
  // flag and captured word cleared, abandoning any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      size_q      <= '0;
      p_q         <= '0;
      j_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      err_q       <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bad_state_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      p_q         <= p_d;
      j_q         <= j_d;
      a_q         <= a_d;
      b_q         <= b_d;
      err_q       <= err_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bad_state_q <= bad_state_d;
    end
  end

  // Next-state and output decode. Bus outputs are pure functions of the
  // registered state, so they are all zero in IDLE and therefore zero the
  // moment reset is asserted. Addresses and write data only change between
  // transactions, so they are stable while the matching valid is high.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    p_d         = p_q;
    j_d         = j_q;
    a_d         = a_q;
    b_d         = b_q;
    err_d       = err_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bad_state_d = bad_state_q;

    done        = 1'b0;
    ar_valid    = 1'b0;
    ar_address  = '0;
    r_ready     = 1'b0;
    aw_valid    = 1'b0;
    aw_address  = '0;
    w_valid     = 1'b0;
    w_data      = '0;
    b_ready     = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          size_d    = arr_size;
          err_d     = 1'b0;
          p_d       = '0;
          j_d       = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (arr_size > MAX_SIZE) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (arr_size <= SIZE_ONE) begin
            state_d = DONE;
          end else begin
            state_d = RD_A_ADDR;
          end
        end
      end

      RD_A_ADDR: begin
        ar_valid   = 1'b1;
        ar_address = j_q;
        if (ar_ready) begin
          state_d = RD_A_DATA;
        end
      end

      RD_A_DATA: begin
        r_ready = 1'b1;
        if (r_valid) begin
          if (r_resp != '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            a_d     = r_data;
            state_d = RD_B_ADDR;
          end
        end
      end

      RD_B_ADDR: begin
        ar_valid   = 1'b1;
        ar_address = j_plus1;
        if (ar_ready) begin
          state_d = RD_B_DATA;
        end
      end

      RD_B_DATA: begin
        r_ready = 1'b1;
        if (r_valid) begin
          if (r_resp != '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            b_d     = r_data;
            state_d = COMPARE;
          end
        end
      end

      // Strictly greater-than so equal elements are never rewritten.
      COMPARE: begin
        if (a_q > b_q) begin
          state_d = WR_A;
        end else if (last_pair) begin
          state_d = DONE;
        end else begin
          state_d = NEXT;
        end
      end

      // Address and data go out together; each valid drops on its own
      // handshake and the state moves on once both have been accepted.
      WR_A: begin
        aw_valid   = !aw_done_q;
        w_valid    = !w_done_q;
        aw_address = j_q;
        w_data     = b_q;
        aw_fire    = aw_valid && aw_ready;
        w_fire     = w_valid && w_ready;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_A_RESP;
        end else begin
          aw_done_d = aw_done_q || aw_fire;
          w_done_d  = w_done_q || w_fire;
        end
      end

      WR_A_RESP: begin
        b_ready = 1'b1;
        if (b_valid) begin
          if (b_resp != '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WR_B;
          end
        end
      end

      WR_B: begin
        aw_valid   = !aw_done_q;
        w_valid    = !w_done_q;
        aw_address = j_plus1;
        w_data     = a_q;
        aw_fire    = aw_valid && aw_ready;
        w_fire     = w_valid && w_ready;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_B_RESP;
        end else begin
          aw_done_d = aw_done_q || aw_fire;
          w_done_d  = w_done_q || w_fire;
        end
      end

      WR_B_RESP: begin
        b_ready = 1'b1;
        if (b_valid) begin
          if (b_resp != '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (last_pair) begin
            state_d = DONE;
          end else begin
            state_d = NEXT;
          end
        end
      end

      // Advance the loop indices. The final compare never reaches this
      // state, but the pass check keeps the loop bounded regardless.
      NEXT: begin
        if (end_of_pass) begin
          j_d = '0;
          p_d = p_q + ADDR_WDTH'(1);
          if (last_pass) begin
            state_d = DONE;
          end else begin
            state_d = RD_A_ADDR;
          end
        end else begin
          j_d     = j_plus1;
          state_d = RD_A_ADDR;
        end
      end

      // Hold the result until the requester drops start, so a level start
      // never triggers a second sort.
      DONE: begin
        done = 1'b1;
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        bad_state_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sort_circuit.sv
// ---------------------------------------------------------------------------
// tb_sort_circuit
//
// Drives sort_circuit against a 16-word behavioural memory with stalling
// ready signals. Each directed vector pushes its hand-computed outcome into
// a scoreboard queue; a separate monitor pops it when done rises and
// compares err, handshake counts and the final memory image.
// ---------------------------------------------------------------------------
module tb_sort_circuit;

  localparam int ADDR_WDTH = 4;
  localparam int DATA_WDTH = 32;
  localparam int RESP_WDTH = 1;
  localparam int DEPTH     = 16;

  logic                 clk;
  logic                 rst_n;
  logic [ADDR_WDTH:0]   arr_size;
  logic                 start;
  logic                 done;
  logic                 err;
  logic                 ar_valid;
  logic                 ar_ready;
  logic [ADDR_WDTH-1:0] ar_address;
  logic                 r_valid;
  logic                 r_ready;
  logic [DATA_WDTH-1:0] r_data;
  logic [RESP_WDTH-1:0] r_resp;
  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_WDTH-1:0] aw_address;
  logic                 w_valid;
  logic                 w_ready;
  logic [DATA_WDTH-1:0] w_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [RESP_WDTH-1:0] b_resp;
  logic                 swich_case_default;

  sort_circuit #(
    .ADDR_WDTH(ADDR_WDTH),
    .DATA_WDTH(DATA_WDTH),
    .RESP_WDTH(RESP_WDTH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .arr_size          (arr_size),
    .start             (start),
    .done              (done),
    .err               (err),
    .ar_valid          (ar_valid),
    .ar_ready          (ar_ready),
    .ar_address        (ar_address),
    .r_valid           (r_valid),
    .r_ready           (r_ready),
    .r_data            (r_data),
    .r_resp            (r_resp),
    .aw_valid          (aw_valid),
    .aw_ready          (aw_ready),
    .aw_address        (aw_address),
    .w_valid           (w_valid),
    .w_ready           (w_ready),
    .w_data            (w_data),
    .b_valid           (b_valid),
    .b_ready           (b_ready),
    .b_resp            (b_resp),
    .swich_case_default(swich_case_default)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [DEPTH-1:0][DATA_WDTH-1:0] image_t;

  // Expected outcome of one sort; a negative count means "do not check".
  typedef struct packed {
    int     id;
    logic   exp_err;
    logic   check_mem;
    int     exp_reads;
    int     exp_writes;
    image_t exp_mem;
  } exp_t;

  exp_t                 sb_q[$];
  int                   vectors     = 0;
  int                   miscompares = 0;

  logic [DATA_WDTH-1:0] mem [DEPTH];
  int                   reads;
  int                   writes;
  int                   ar_seen;
  int                   aw_seen;
  int                   r_resp_mode = 0;
  int                   b_resp_mode = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(input int id, input logic e, input logic chk,
                                 input int rd, input int wr, input image_t m);
    exp_t x;
    x.id         = id;
    x.exp_err    = e;
    x.check_mem  = chk;
    x.exp_reads  = rd;
    x.exp_writes = wr;
    x.exp_mem    = m;
    return x;
  endfunction

  task automatic loadMem(input image_t m);
    for (int i = 0; i < DEPTH; i++) mem[i] = m[i];
  endtask

  // Memory slave: handshakes are sampled at the rising edge, responses and
  // ready patterns are driven on the falling edge.
  initial begin : slave
    logic                 hs_ar, hs_r, hs_aw, hs_w, hs_b;
    logic [ADDR_WDTH-1:0] smp_ar, smp_aw, rd_addr, wr_addr;
    logic [DATA_WDTH-1:0] smp_w, wr_data;
    logic                 rd_pend, aw_got, w_got;
    int                   tick;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
    rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; tick = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    forever begin
      @(posedge clk);
      hs_ar  = ar_valid && ar_ready;
      hs_r   = r_valid && r_ready;
      hs_aw  = aw_valid && aw_ready;
      hs_w   = w_valid && w_ready;
      hs_b   = b_valid && b_ready;
      smp_ar = ar_address;
      smp_aw = aw_address;
      smp_w  = w_data;
      if (hs_r) reads++;
      if (hs_aw) writes++;
      if (ar_valid) ar_seen++;
      if (aw_valid) aw_seen++;
      @(negedge clk);
      tick++;
      if (!rst_n) begin
        r_valid = 1'b0; b_valid = 1'b0;
        rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      end else begin
        if (hs_ar) begin rd_pend = 1'b1; rd_addr = smp_ar; end
        if (hs_r) r_valid = 1'b0;
        if (rd_pend && !r_valid) begin
          r_valid = 1'b1;
          r_data  = mem[rd_addr];
          r_resp  = RESP_WDTH'(r_resp_mode);
          rd_pend = 1'b0;
        end
        if (hs_aw) begin aw_got = 1'b1; wr_addr = smp_aw; end
        if (hs_w) begin w_got = 1'b1; wr_data = smp_w; end
        if (hs_b) b_valid = 1'b0;
        if (aw_got && w_got) begin
          mem[wr_addr] = wr_data;
          b_valid = 1'b1;
          b_resp  = RESP_WDTH'(b_resp_mode);
          aw_got  = 1'b0;
          w_got   = 1'b0;
        end
      end
      ar_ready = (tick % 3) != 1;
      aw_ready = (tick % 4) != 0;
      w_ready  = (tick % 5) != 2;
    end
  end

  // Monitor: on every rising edge of done, pop and compare one expectation.
  initial begin : monitor
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          checkOutput($sformatf("v%0d_err", e.id), err, e.exp_err);
          if (e.exp_reads >= 0) checkOutput($sformatf("v%0d_reads", e.id), reads, e.exp_reads);
          if (e.exp_reads == 0) checkOutput($sformatf("v%0d_ar_idle", e.id), ar_seen, 0);
          if (e.exp_writes >= 0) checkOutput($sformatf("v%0d_writes", e.id), writes, e.exp_writes);
          if (e.exp_writes == 0) checkOutput($sformatf("v%0d_aw_idle", e.id), aw_seen, 0);
          if (e.check_mem) begin
            for (int i = 0; i < DEPTH; i++)
              checkOutput($sformatf("v%0d_mem[%0d]", e.id, i), mem[i], e.exp_mem[i]);
          end
        end
      end
      prev_done = done;
    end
  end

  // Bounded wait for done, then check that a held start does not restart
  // the sort and that dropping start releases done.
  task automatic waitDone(input int limit);
    int cycles;
    int reads_snap;
    cycles = 0;
    while (!done && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("done_within_budget", done, 1);
    if (!done) begin
      void'(sb_q.pop_back());
      start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      return;
    end
    reads_snap = reads;
    repeat (3) @(negedge clk);
    checkOutput("done_held", done, 1);
    checkOutput("no_restart_reads", reads, reads_snap);
    start = 1'b0;
    @(negedge clk);
    checkOutput("done_released", done, 0);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int size, input exp_t e, input int limit,
                               input int r_mode, input int b_mode);
    r_resp_mode = r_mode;
    b_resp_mode = b_mode;
    reads = 0; writes = 0; ar_seen = 0; aw_seen = 0;
    sb_q.push_back(e);
    arr_size = (ADDR_WDTH+1)'(size);
    start    = 1'b1;
    waitDone(limit);
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    image_t init_m, exp_m;
    logic [DATA_WDTH-1:0] s [DEPTH];
    logic [DATA_WDTH-1:0] t;

    rst_n = 1'b0; start = 1'b0; arr_size = '0;
    reads = 0; writes = 0; ar_seen = 0; aw_seen = 0;
    #1;
    checkOutput("reset_outputs",
                {done, err, ar_valid, r_ready, aw_valid, w_valid, b_ready,
                 ar_address, aw_address, w_data, swich_case_default}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // v1: fully reversed -> every compare swaps
    for (int i = 0; i < DEPTH; i++) begin
      init_m[i] = DATA_WDTH'(DEPTH - 1 - i);
      exp_m[i]  = DATA_WDTH'(i);
    end
    loadMem(init_m);
    applyStimulus(16, mkExp(1, 1'b0, 1'b1, 240, 240, exp_m), 20000, 0, 0);

    // v2: already ascending -> 120 compares, no writes
    for (int i = 0; i < DEPTH; i++) init_m[i] = DATA_WDTH'(100 + 3 * i);
    loadMem(init_m);
    applyStimulus(16, mkExp(2, 1'b0, 1'b1, 240, 0, init_m), 20000, 0, 0);

    // v3: duplicates {5,5,3,5}; words above the array must stay untouched
    for (int i = 0; i < DEPTH; i++) init_m[i] = DATA_WDTH'(32'hA0 + i);
    init_m[0] = 32'd5; init_m[1] = 32'd5; init_m[2] = 32'd3; init_m[3] = 32'd5;
    exp_m = init_m;
    exp_m[0] = 32'd3; exp_m[1] = 32'd5; exp_m[2] = 32'd5; exp_m[3] = 32'd5;
    loadMem(init_m);
    applyStimulus(4, mkExp(3, 1'b0, 1'b1, 12, 4, exp_m), 5000, 0, 0);

    // v4: smallest real sort, two elements out of order
    init_m[0] = 32'd9; init_m[1] = 32'd4;
    exp_m = init_m;
    exp_m[0] = 32'd4; exp_m[1] = 32'd9;
    loadMem(init_m);
    applyStimulus(2, mkExp(4, 1'b0, 1'b1, 2, 2, exp_m), 1000, 0, 0);

    // v5: read error on the first R handshake
    for (int i = 0; i < DEPTH; i++) init_m[i] = DATA_WDTH'(DEPTH - 1 - i);
    loadMem(init_m);
    applyStimulus(16, mkExp(5, 1'b1, 1'b1, 1, 0, init_m), 1000, 1, 1);

    // v6: write error on the first B handshake
    init_m[0] = 32'd9; init_m[1] = 32'd4;
    loadMem(init_m);
    applyStimulus(2, mkExp(6, 1'b1, 1'b0, 2, 1, init_m), 1000, 0, 1);

    // v7..v9: sizes needing no bus traffic, done within two cycles
    loadMem(init_m);
    applyStimulus(1,  mkExp(7, 1'b0, 1'b1, 0, 0, init_m), 2, 0, 0);
    applyStimulus(17, mkExp(8, 1'b1, 1'b1, 0, 0, init_m), 2, 0, 0);
    applyStimulus(0,  mkExp(9, 1'b0, 1'b1, 0, 0, init_m), 2, 0, 0);

    // v10: asynchronous reset in the middle of a sort, then rerun
    for (int i = 0; i < DEPTH; i++) init_m[i] = DATA_WDTH'(200 - 7 * i);
    loadMem(init_m);
    r_resp_mode = 0; b_resp_mode = 0;
    arr_size = 5'd16;
    start    = 1'b1;
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midsort_reset_outputs",
                {done, err, ar_valid, r_ready, aw_valid, w_valid, b_ready,
                 ar_address, aw_address, w_data, swich_case_default}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) s[i] = mem[i];
    for (int p = 0; p < DEPTH - 1; p++)
      for (int j = 0; j < DEPTH - 1 - p; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    for (int i = 0; i < DEPTH; i++) exp_m[i] = s[i];
    reads = 0; writes = 0; ar_seen = 0; aw_seen = 0;
    sb_q.push_back(mkExp(10, 1'b0, 1'b1, 240, -1, exp_m));
    @(negedge clk);
    waitDone(20000);

    repeat (2) @(negedge clk);
    checkOutput("swich_case_default", swich_case_default, 0);
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
